rob_commit_ctrl: RTL and testbench
==================================

// Module: rob_commit_ctrl
// PURPOSE
//   In-order allocate/commit sequencer for the renamed register file. Hands out
//   ROB tags at dispatch and drives the RegFile rename port (rd_in_*). Collects
//   out-of-order writebacks and retires them strictly in tag order through the
//   RegFile commit port (rd_out_*). Sits between decode/dispatch, the CDB and RegFile.
// PARAMETERS
//   TAG_W   4   ROB tag width; must match RegFile rename tag width
//   DEPTH   16  entries, = 2**TAG_W
//   DATA_W  32  result width
// PORTS
//   clk          in   1       clock; all state updates on posedge
//   rst          in   1       synchronous reset, active-high
//   rdy          in   1       global enable; 0 = freeze all state
//   alloc_valid  in   1       dispatch requests an entry
//   alloc_rd     in   5       destination arch register (0 allowed)
//   alloc_ready  out  1       entry available this cycle
//   alloc_tag    out  TAG_W   tag granted on handshake (= tail)
//   wb_valid     in   1       result broadcast
//   wb_tag       in   TAG_W   tag of result
//   wb_val       in   DATA_W  result value
//   flush        in   1       squash all in-flight entries
//   rf_flush     out  1       one-cycle pulse: RegFile must drop all renames
//   rd_in_flag   out  1       RegFile rename write enable
//   rd_in_a      out  5       = alloc_rd
//   rd_in_rob    out  TAG_W   = alloc_tag
//   rd_out_flag  out  1       RegFile commit write enable (registered)
//   rd_out_a     out  5       committed arch register (registered)
//   rd_out_val   out  DATA_W  committed value (registered)
//   rd_out_rob   out  TAG_W   committed tag (registered)
//   count        out  TAG_W+1 occupied entries
// BEHAVIOUR
//   - Storage: circular buffer, per entry {busy, done, rd, val}; head, tail TAG_W bits, wrap 15->0.
//   - FSM: RUN, FLUSH. rst -> RUN. flush=1 (any state, if rdy) -> FLUSH; FLUSH -> RUN after 1 cycle.
//   - Reset: all busy/done=0, head=tail=count=0; all outputs 0 except alloc_tag=0;
//     alloc_ready=0 in the reset cycle, 1 the cycle after.
//   - alloc_ready = (state==RUN) & (count<DEPTH) & !flush. Uses count before any same-cycle commit (no bypass).
//   - Alloc handshake = alloc_valid & alloc_ready & rdy. Combinational: rd_in_flag = handshake,
//     rd_in_a/rd_in_rob follow alloc_rd/alloc_tag. At posedge: entry[tail] <= {1,0,alloc_rd,x}; tail++.
//   - Writeback (wb_valid & rdy): if entry[wb_tag].busy, set done, store val; else ignore silently.
//     Writeback to the tag being allocated the same cycle is ignored (not yet busy).
//   - Commit: at posedge, if rdy & RUN & !flush & entry[head].busy & entry[head].done:
//     rd_out_* <= {1, rd, val, head}; clear busy/done; head++. Max one commit per cycle.
//     Otherwise rd_out_flag <= 0 (pulse is exactly one cycle per commit).
//   - Latency: wb sampled at edge E -> rd_out_flag high E+1..E+2 if entry is head.
//   - rd=0 entries commit normally with rd_out_a=0 (RegFile discards).
//   - count: +1 on alloc, -1 on commit, unchanged if both.
//   - flush (rdy=1): highest priority; rd_in_flag forced 0 that cycle; at posedge clear all
//     busy/done, head=tail=count=0, rd_out_flag<=0, rf_flush<=1 (one cycle). Pending wb dropped.
//   - rdy=0: no state change, rd_in_flag=0, rd_out_flag<=0, rf_flush<=0, flush ignored.
//   - rst mid-operation: same as reset; overrides flush and rdy.
// TESTING
//   1. rst; alloc rd=5 -> tag0, rd_in_flag=1,rd_in_rob=0; wb tag0 0xDEADBEEF -> next cycle
//      rd_out_flag=1, rd_out_a=5, rd_out_val=0xDEADBEEF, rd_out_rob=0, count back to 0.
//   2. Alloc tags 0,1,2 (rd 1,2,3); wb order 2,1,0 -> commits rob 0,1,2 on 3 consecutive cycles.
//   3. 16 allocs, no wb -> count=16, alloc_ready=0, 17th held; wb tag0 -> commit, alloc_ready=1
//      the cycle after commit, granted tag=0.
//   4. 20 alloc/wb/commit pairs -> alloc_tag and rd_out_rob wrap 15 -> 0 -> 3, no lost commits.
//   5. 3 entries, tags 0,1 done, assert flush with tag0 committable -> no rd_out_flag,
//      rf_flush pulse 1 cycle, alloc_ready=0 in FLUSH, then next alloc gets tag 0.
//   6. Head done, rdy=0 for 3 cycles -> no commit, no state change; rdy=1 -> commit next edge.

Source files
------------

// File: rtl/rob_commit_ctrl.sv
// Purpose: in-order ROB tag allocator / commit sequencer between dispatch, the CDB and RegFile.
// Latency: rename port combinational; a writeback sampled at edge E commits at edge E+1 (rd_out_* registered).
// Backpressure: alloc_ready drops when full, during flush/FLUSH state and in reset; rdy=0 freezes everything.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   alloc_valid/alloc_rd/alloc_ready/alloc_tag : dispatch handshake, tag = tail
//   wb_valid/wb_tag/wb_val                     : CDB result broadcast
//   flush / rf_flush                           : squash request / one-cycle RegFile rename drop
//   rd_in_*                                    : RegFile rename port (combinational)
//   rd_out_*                                   : RegFile commit port (registered)
//   count                                      : occupied entries
module rob_commit_ctrl #(
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              alloc_valid,
  input  logic [4:0]        alloc_rd,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              wb_valid,
  input  logic [TAG_W-1:0]  wb_tag,
  input  logic [DATA_W-1:0] wb_val,
  input  logic              flush,
  output logic              rf_flush,
  output logic              rd_in_flag,
  output logic [4:0]        rd_in_a,
  output logic [TAG_W-1:0]  rd_in_rob,
  output logic              rd_out_flag,
  output logic [4:0]        rd_out_a,
  output logic [DATA_W-1:0] rd_out_val,
  output logic [TAG_W-1:0]  rd_out_rob,
  output logic [TAG_W:0]    count
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);

  state_t              state_q, state_d;
  logic [DEPTH-1:0]    busy_q, busy_d;
  logic [DEPTH-1:0]    done_q, done_d;
  logic [4:0]          rd_q  [DEPTH];
  logic [4:0]          rd_d  [DEPTH];
  logic [DATA_W-1:0]   val_q [DEPTH];
  logic [DATA_W-1:0]   val_d [DEPTH];
  logic [TAG_W-1:0]    head_q, head_d;
  logic [TAG_W-1:0]    tail_q, tail_d;
  logic [TAG_W:0]      count_q, count_d;
  logic                rd_out_flag_q, rd_out_flag_d;
  logic [4:0]          rd_out_a_q, rd_out_a_d;
  logic [DATA_W-1:0]   rd_out_val_q, rd_out_val_d;
  logic [TAG_W-1:0]    rd_out_rob_q, rd_out_rob_d;
  logic                rf_flush_q, rf_flush_d;

  logic alloc_fire;
  logic commit_fire;
  logic wb_fire;

  // Ready is based on the pre-edge count: a same-cycle commit does not free a slot early.
  assign alloc_ready = !rst && (state_q == ST_RUN) && (count_q != DEPTH_C) && !flush;
  assign alloc_fire  = alloc_valid && alloc_ready && rdy;
  assign commit_fire = rdy && (state_q == ST_RUN) && !flush && busy_q[head_q] && done_q[head_q];
  // busy_q is the pre-edge view, so a writeback to the tag being allocated right now is dropped.
  assign wb_fire     = rdy && !flush && wb_valid && busy_q[wb_tag];

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    rd_d          = rd_q;
    val_d         = val_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    rd_out_flag_d = 1'b0;
    rd_out_a_d    = rd_out_a_q;
    rd_out_val_d  = rd_out_val_q;
    rd_out_rob_d  = rd_out_rob_q;
    rf_flush_d    = 1'b0;

    if (rdy) begin
      if (flush) begin
        state_d    = ST_FLUSH;
        busy_d     = '0;
        done_d     = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        rf_flush_d = 1'b1;
      end else begin
        if (state_q == ST_FLUSH) state_d = ST_RUN;

        if (wb_fire) begin
          done_d[wb_tag] = 1'b1;
          val_d[wb_tag]  = wb_val;
        end

        // Commit reads pre-edge entry contents; its clear wins over any redundant writeback.
        if (commit_fire) begin
          busy_d[head_q] = 1'b0;
          done_d[head_q] = 1'b0;
          rd_out_flag_d  = 1'b1;
          rd_out_a_d     = rd_q[head_q];
          rd_out_val_d   = val_q[head_q];
          rd_out_rob_d   = head_q;
          head_d         = head_q + TAG_ONE;
        end

        // tail never equals a committing head here: alloc is blocked when full.
        if (alloc_fire) begin
          busy_d[tail_q] = 1'b1;
          done_d[tail_q] = 1'b0;
          rd_d[tail_q]   = alloc_rd;
          tail_d         = tail_q + TAG_ONE;
        end

        case ({alloc_fire, commit_fire})
          2'b10:   count_d = count_q + CNT_ONE;
          2'b01:   count_d = count_q - CNT_ONE;
          default: count_d = count_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      busy_q        <= '0;
      done_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      rd_out_flag_q <= 1'b0;
      rd_out_a_q    <= '0;
      rd_out_val_q  <= '0;
      rd_out_rob_q  <= '0;
      rf_flush_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      rd_out_flag_q <= rd_out_flag_d;
      rd_out_a_q    <= rd_out_a_d;
      rd_out_val_q  <= rd_out_val_d;
      rd_out_rob_q  <= rd_out_rob_d;
      rf_flush_q    <= rf_flush_d;
    end
  end

  // Payload storage is qualified by busy/done, so it needs no reset.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    val_q <= val_d;
  end

  assign alloc_tag   = tail_q;
  assign rd_in_flag  = alloc_fire;
  assign rd_in_a     = alloc_rd;
  assign rd_in_rob   = tail_q;
  assign rd_out_flag = rd_out_flag_q;
  assign rd_out_a    = rd_out_a_q;
  assign rd_out_val  = rd_out_val_q;
  assign rd_out_rob  = rd_out_rob_q;
  assign rf_flush    = rf_flush_q;
  assign count       = count_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
module tb_rob_commit_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        alloc_valid;
  logic [4:0]  alloc_rd;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        wb_valid;
  logic [3:0]  wb_tag;
  logic [31:0] wb_val;
  logic        flush;
  logic        rf_flush;
  logic        rd_in_flag;
  logic [4:0]  rd_in_a;
  logic [3:0]  rd_in_rob;
  logic        rd_out_flag;
  logic [4:0]  rd_out_a;
  logic [31:0] rd_out_val;
  logic [3:0]  rd_out_rob;
  logic [4:0]  count;

  int tests_run    = 0;
  int tests_failed = 0;

  rob_commit_ctrl #(.TAG_W(4), .DEPTH(16), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
    .flush(flush), .rf_flush(rf_flush),
    .rd_in_flag(rd_in_flag), .rd_in_a(rd_in_a), .rd_in_rob(rd_in_rob),
    .rd_out_flag(rd_out_flag), .rd_out_a(rd_out_a),
    .rd_out_val(rd_out_val), .rd_out_rob(rd_out_rob),
    .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_val = '0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b1; alloc_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_val = '0; flush = 1'b0;
    #1;
    tests_run++; if (alloc_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_alloc_ready_in_rst: got %0b want 0", alloc_ready); end
    tests_run++; if (rd_in_flag !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_in_flag: got %0b want 0", rd_in_flag); end
    @(negedge clk);
    tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count: got %0d want 0", count); end
    tests_run++; if (alloc_tag !== 4'd0) begin tests_failed++; $display("FAIL reset_alloc_tag: got %0d want 0", alloc_tag); end
    tests_run++; if ({rd_out_flag, rf_flush, rd_out_a, rd_out_val, rd_out_rob} !== '0) begin tests_failed++; $display("FAIL reset_outputs: got flag=%0b rf_flush=%0b a=%0d val=%0h rob=%0d want all 0", rd_out_flag, rf_flush, rd_out_a, rd_out_val, rd_out_rob); end
    rst = 1'b0; alloc_valid = 1'b0;
    #1;
    tests_run++; if (alloc_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_alloc_ready_after: got %0b want 1", alloc_ready); end
  endtask

  task automatic test_single;
    do_reset;
    @(negedge clk);
    alloc_valid = 1'b1; alloc_rd = 5'd5; #1;
    tests_run++; if ({rd_in_flag, rd_in_a, rd_in_rob, alloc_tag} !== {1'b1, 5'd5, 4'd0, 4'd0}) begin tests_failed++; $display("FAIL single_rename: got flag=%0b a=%0d rob=%0d tag=%0d want 1 5 0 0", rd_in_flag, rd_in_a, rd_in_rob, alloc_tag); end
    @(negedge clk);
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 4'd0; wb_val = 32'hDEADBEEF; #1;
    tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL single_count_alloc: got %0d want 1", count); end
    @(negedge clk);
    wb_valid = 1'b0;
    tests_run++; if (rd_out_flag !== 1'b0) begin tests_failed++; $display("FAIL single_no_early_commit: got %0b want 0", rd_out_flag); end
    @(negedge clk);
    tests_run++; if ({rd_out_flag, rd_out_a, rd_out_val, rd_out_rob, count} !== {1'b1, 5'd5, 32'hDEADBEEF, 4'd0, 5'd0}) begin tests_failed++; $display("FAIL single_commit: got flag=%0b a=%0d val=%0h rob=%0d count=%0d want 1 5 deadbeef 0 0", rd_out_flag, rd_out_a, rd_out_val, rd_out_rob, count); end
    @(negedge clk);
    tests_run++; if (rd_out_flag !== 1'b0) begin tests_failed++; $display("FAIL single_pulse_width: got %0b want 0", rd_out_flag); end
  endtask

  task automatic test_out_of_order;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1); #1;
      tests_run++; if (alloc_tag !== 4'(i)) begin tests_failed++; $display("FAIL ooo_alloc_tag%0d: got %0d want %0d", i, alloc_tag, i); end
    end
    for (int i = 2; i >= 0; i--) begin
      @(negedge clk);
      alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 4'(i); wb_val = 32'hA0 + 32'(i);
      tests_run++; if (rd_out_flag !== 1'b0) begin tests_failed++; $display("FAIL ooo_no_commit_before_head: got %0b want 0", rd_out_flag); end
    end
    @(negedge clk);
    wb_valid = 1'b0;
    tests_run++; if (rd_out_flag !== 1'b0) begin tests_failed++; $display("FAIL ooo_no_commit_yet: got %0b want 0", rd_out_flag); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if ({rd_out_flag, rd_out_rob, rd_out_a, rd_out_val} !== {1'b1, 4'(i), 5'(i + 1), 32'hA0 + 32'(i)}) begin tests_failed++; $display("FAIL ooo_commit%0d: got flag=%0b rob=%0d a=%0d val=%0h want 1 %0d %0d %0h", i, rd_out_flag, rd_out_rob, rd_out_a, rd_out_val, i, i + 1, 32'hA0 + i); end
    end
    @(negedge clk);
    tests_run++; if ({rd_out_flag, count} !== {1'b0, 5'd0}) begin tests_failed++; $display("FAIL ooo_drained: got flag=%0b count=%0d want 0 0", rd_out_flag, count); end
  endtask

  task automatic test_full;
    do_reset;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_rd = 5'(i); #1;
      tests_run++; if (alloc_tag !== 4'(i)) begin tests_failed++; $display("FAIL full_alloc_tag%0d: got %0d want %0d", i, alloc_tag, i); end
    end
    @(negedge clk);
    tests_run++; if ({count, alloc_ready, rd_in_flag} !== {5'd16, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL full_held: got count=%0d ready=%0b flag=%0b want 16 0 0", count, alloc_ready, rd_in_flag); end
    wb_valid = 1'b1; wb_tag = 4'd0; wb_val = 32'h1234;
    @(negedge clk);
    wb_valid = 1'b0;
    tests_run++; if ({count, alloc_ready} !== {5'd16, 1'b0}) begin tests_failed++; $display("FAIL full_no_bypass: got count=%0d ready=%0b want 16 0", count, alloc_ready); end
    @(negedge clk);
    tests_run++; if ({rd_out_flag, rd_out_rob, rd_out_val, count} !== {1'b1, 4'd0, 32'h1234, 5'd15}) begin tests_failed++; $display("FAIL full_commit: got flag=%0b rob=%0d val=%0h count=%0d want 1 0 1234 15", rd_out_flag, rd_out_rob, rd_out_val, count); end
    tests_run++; if ({alloc_ready, alloc_tag, rd_in_flag} !== {1'b1, 4'd0, 1'b1}) begin tests_failed++; $display("FAIL full_regrant: got ready=%0b tag=%0d flag=%0b want 1 0 1", alloc_ready, alloc_tag, rd_in_flag); end
    @(negedge clk);
    alloc_valid = 1'b0;
    tests_run++; if ({count, alloc_tag, rd_out_flag} !== {5'd16, 4'd1, 1'b0}) begin tests_failed++; $display("FAIL full_refill: got count=%0d tag=%0d flag=%0b want 16 1 0", count, alloc_tag, rd_out_flag); end
  endtask

  task automatic test_wrap;
    int commits;
    commits = 0;
    do_reset;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_rd = 5'(i); #1;
      tests_run++; if (alloc_tag !== 4'(i % 16)) begin tests_failed++; $display("FAIL wrap_tag%0d: got %0d want %0d", i, alloc_tag, i % 16); end
      @(negedge clk);
      alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 4'(i % 16); wb_val = 32'h5000 + 32'(i);
      @(negedge clk);
      wb_valid = 1'b0;
      @(negedge clk);
      if (rd_out_flag === 1'b1) commits++;
      tests_run++; if ({rd_out_flag, rd_out_rob, rd_out_a, rd_out_val} !== {1'b1, 4'(i % 16), 5'(i), 32'h5000 + 32'(i)}) begin tests_failed++; $display("FAIL wrap_commit%0d: got flag=%0b rob=%0d a=%0d val=%0h", i, rd_out_flag, rd_out_rob, rd_out_a, rd_out_val); end
    end
    tests_run++; if ({commits, count} !== {32'd20, 5'd0}) begin tests_failed++; $display("FAIL wrap_total: got commits=%0d count=%0d want 20 0", commits, count); end
  endtask

  task automatic test_flush;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      alloc_valid = 1'b1; alloc_rd = 5'(10 + i);
    end
    @(negedge clk);
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 4'd1; wb_val = 32'h11;
    @(negedge clk);
    wb_tag = 4'd0; wb_val = 32'h10;
    @(negedge clk);
    wb_valid = 1'b0; flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd7; #1;
    tests_run++; if ({alloc_ready, rd_in_flag} !== {1'b0, 1'b0}) begin tests_failed++; $display("FAIL flush_blocks_alloc: got ready=%0b flag=%0b want 0 0", alloc_ready, rd_in_flag); end
    @(negedge clk);
    flush = 1'b0; #1;
    tests_run++; if ({rd_out_flag, rf_flush, count, alloc_tag} !== {1'b0, 1'b1, 5'd0, 4'd0}) begin tests_failed++; $display("FAIL flush_state: got out_flag=%0b rf_flush=%0b count=%0d tag=%0d want 0 1 0 0", rd_out_flag, rf_flush, count, alloc_tag); end
    tests_run++; if ({alloc_ready, rd_in_flag} !== {1'b0, 1'b0}) begin tests_failed++; $display("FAIL flush_fsm_ready: got ready=%0b flag=%0b want 0 0", alloc_ready, rd_in_flag); end
    @(negedge clk); #1;
    tests_run++; if ({rf_flush, rd_out_flag, alloc_ready, alloc_tag, rd_in_flag} !== {1'b0, 1'b0, 1'b1, 4'd0, 1'b1}) begin tests_failed++; $display("FAIL flush_recover: got rf_flush=%0b out_flag=%0b ready=%0b tag=%0d flag=%0b want 0 0 1 0 1", rf_flush, rd_out_flag, alloc_ready, alloc_tag, rd_in_flag); end
    @(negedge clk);
    alloc_valid = 1'b0;
    tests_run++; if ({count, alloc_tag, rd_out_flag} !== {5'd1, 4'd1, 1'b0}) begin tests_failed++; $display("FAIL flush_realloc: got count=%0d tag=%0d flag=%0b want 1 1 0", count, alloc_tag, rd_out_flag); end
  endtask

  task automatic test_rdy_stall;
    do_reset;
    @(negedge clk);
    alloc_valid = 1'b1; alloc_rd = 5'd9;
    @(negedge clk);
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_tag = 4'd0; wb_val = 32'h55;
    @(negedge clk);
    wb_valid = 1'b0; rdy = 1'b0;
    @(negedge clk);
    flush = 1'b1; alloc_valid = 1'b1; #1;
    tests_run++; if ({rd_out_flag, count, rd_in_flag} !== {1'b0, 5'd1, 1'b0}) begin tests_failed++; $display("FAIL stall_frozen1: got flag=%0b count=%0d in_flag=%0b want 0 1 0", rd_out_flag, count, rd_in_flag); end
    @(negedge clk);
    flush = 1'b0; alloc_valid = 1'b0;
    tests_run++; if ({rd_out_flag, rf_flush, count} !== {1'b0, 1'b0, 5'd1}) begin tests_failed++; $display("FAIL stall_flush_ignored: got flag=%0b rf_flush=%0b count=%0d want 0 0 1", rd_out_flag, rf_flush, count); end
    @(negedge clk);
    rdy = 1'b1; #1;
    tests_run++; if ({rd_out_flag, rf_flush, count, alloc_ready, alloc_tag} !== {1'b0, 1'b0, 5'd1, 1'b1, 4'd1}) begin tests_failed++; $display("FAIL stall_frozen3: got flag=%0b rf_flush=%0b count=%0d ready=%0b tag=%0d want 0 0 1 1 1", rd_out_flag, rf_flush, count, alloc_ready, alloc_tag); end
    @(negedge clk);
    tests_run++; if ({rd_out_flag, rd_out_rob, rd_out_a, rd_out_val, count} !== {1'b1, 4'd0, 5'd9, 32'h55, 5'd0}) begin tests_failed++; $display("FAIL stall_resume_commit: got flag=%0b rob=%0d a=%0d val=%0h count=%0d want 1 0 9 55 0", rd_out_flag, rd_out_rob, rd_out_a, rd_out_val, count); end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; alloc_valid = 1'b0; alloc_rd = '0;
    wb_valid = 1'b0; wb_tag = '0; wb_val = '0; flush = 1'b0;
    test_reset;
    test_single;
    test_out_of_order;
    test_full;
    test_wrap;
    test_flush;
    test_rdy_stall;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
